exception_sequencer: RTL and testbench

Multicycle-CPU exception sequencer. It sits directly upstream of the exception vector decoder, which maps a 2-bit cause to handler-vector addresses 253/254/255. It detects the three architectural exceptions, saves the faulting PC into EPC, and drives the cause code while the vector byte is read from memory. It then loads the PC with the zero-extended handler address and stalls the main control unit for the whole sequence.

---
 rtl/exc_pkg.sv | 20 ++
 rtl/exc_priority_enc.sv | 26 ++
 rtl/exception_sequencer.sv | 130 +++++++++++++
 tb/tb_exception_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE_EPC = 2'd1,
    READ_VEC = 2'd2,
    LOAD_PC  = 2'd3
  } exc_state_t;

  // Cause codes seen by the vector decoder (handlers at 253/254/255).
  localparam logic [1:0]  EXC_OPCODE   = 2'd0;
  localparam logic [1:0]  EXC_OVERFLOW = 2'd1;
  localparam logic [1:0]  EXC_DIV0     = 2'd2;

  // Fetch has already advanced the PC by one word; EPC must point back at
  // the faulting instruction.
  localparam logic [31:0] EPC_OFFSET   = 32'd4;

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority encoder for the three exception flags:
// invalid opcode beats overflow beats divide-by-zero.
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic       i_invalid_opcode,
  input  logic       i_overflow,
  input  logic       i_div_zero,
  output logic       o_valid,
  output logic [1:0] o_cause
);

  // Pick the highest-priority pending flag; cause is don't-care when invalid.
  always_comb begin
    o_valid = i_invalid_opcode | i_overflow | i_div_zero;
    o_cause = EXC_OPCODE;
    if (i_invalid_opcode) begin
      o_cause = EXC_OPCODE;
    end else if (i_overflow) begin
      o_cause = EXC_OVERFLOW;
    end else if (i_div_zero) begin
      o_cause = EXC_DIV0;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Multicycle-CPU exception sequencer: latches the cause and faulting PC,
// fetches the handler vector byte and loads the PC, stalling main control.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a flag; cause and pc_in-4 latched on exit
// SAVE_EPC | one-cycle EPC write of the latched faulting PC
// READ_VEC | mem_read held for MEM_LATENCY cycles, byte latched on last
// LOAD_PC  | one-cycle PC write of the zero-extended handler address
module exception_sequencer
  import exc_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        invalid_opcode,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_data,
  output logic [1:0]  exc_code,
  output logic        epc_write,
  output logic [31:0] epc_value,
  output logic        mem_read,
  output logic        pc_write,
  output logic [31:0] pc_value,
  output logic        exc_busy
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  exc_state_t  r_state;
  exc_state_t  w_state_nxt;
  logic [1:0]  r_cause;
  logic [31:0] r_epc;
  logic [2:0]  r_cnt;
  logic [7:0]  r_handler;
  logic        w_valid;
  logic [1:0]  w_cause;

  exc_priority_enc u_prio (
    .i_invalid_opcode (invalid_opcode),
    .i_overflow       (overflow),
    .i_div_zero       (div_zero),
    .o_valid          (w_valid),
    .o_cause          (w_cause)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; outputs decode from state and registers only, so the
  // flags never reach an output combinationally.
  always_comb begin
    w_state_nxt = r_state;
    epc_write   = 1'b0;
    mem_read    = 1'b0;
    pc_write    = 1'b0;
    exc_busy    = 1'b1;
    unique case (r_state)
      IDLE: begin
        exc_busy = 1'b0;
        if (w_valid) begin
          w_state_nxt = SAVE_EPC;
        end
      end
      SAVE_EPC: begin
        epc_write   = 1'b1;
        w_state_nxt = READ_VEC;
      end
      READ_VEC: begin
        mem_read = 1'b1;
        if (r_cnt == 3'd0) begin
          w_state_nxt = LOAD_PC;
        end
      end
      LOAD_PC: begin
        pc_write    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers: cause/EPC captured on IDLE exit so later PC motion is
  // ignored; latency down-counter armed in SAVE_EPC, vector byte taken at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cause   <= EXC_OPCODE;
      r_epc     <= 32'd0;
      r_cnt     <= 3'd0;
      r_handler <= 8'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_cause <= w_cause;
            r_epc   <= pc_in - EPC_OFFSET;
          end
        end
        SAVE_EPC: begin
          r_cnt <= LAT_M1;
        end
        READ_VEC: begin
          if (r_cnt == 3'd0) begin
            r_handler <= mem_data;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign exc_code  = r_cause;
  assign epc_value = r_epc;
  assign pc_value  = {24'd0, r_handler};

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: one instance at MEM_LATENCY=1 and
// one at MEM_LATENCY=4, inputs driven and outputs sampled on falling edges.
module tb_exception_sequencer;

  logic        clk;
  logic        reset;
  logic        invalid_opcode, overflow, div_zero;
  logic [31:0] pc_in;
  logic [7:0]  mem_data;
  logic [1:0]  exc_code;
  logic        epc_write, mem_read, pc_write, exc_busy;
  logic [31:0] epc_value, pc_value;

  logic        invalid_opcode_4, overflow_4, div_zero_4;
  logic [31:0] pc_in_4;
  logic [7:0]  mem_data_4;
  logic [1:0]  exc_code_4;
  logic        epc_write_4, mem_read_4, pc_write_4, exc_busy_4;
  logic [31:0] epc_value_4, pc_value_4;

  int n_checks = 0;
  int n_fail   = 0;

  exception_sequencer #(.MEM_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .invalid_opcode(invalid_opcode), .overflow(overflow), .div_zero(div_zero),
    .pc_in(pc_in), .mem_data(mem_data),
    .exc_code(exc_code), .epc_write(epc_write), .epc_value(epc_value),
    .mem_read(mem_read), .pc_write(pc_write), .pc_value(pc_value),
    .exc_busy(exc_busy)
  );

  exception_sequencer #(.MEM_LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .invalid_opcode(invalid_opcode_4), .overflow(overflow_4), .div_zero(div_zero_4),
    .pc_in(pc_in_4), .mem_data(mem_data_4),
    .exc_code(exc_code_4), .epc_write(epc_write_4), .epc_value(epc_value_4),
    .mem_read(mem_read_4), .pc_write(pc_write_4), .pc_value(pc_value_4),
    .exc_busy(exc_busy_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs the rest of a sequence on the latency-1 instance from the current
  // cycle, counting busy cycles and write pulses.
  task automatic drain(output int nb, output int ne, output int np, output logic [31:0] pv);
    nb = 0; ne = 0; np = 0; pv = 32'hFFFF_FFFF;
    for (int i = 0; i < 32 && exc_busy; i++) begin
      nb++;
      if (epc_write) ne++;
      if (pc_write) begin
        np++;
        pv = pc_value;
      end
      step();
    end
    chk("drain_timeout", 32'(exc_busy), 32'd0);
  endtask

  initial begin
    int nb, ne, np, rd, npulse;
    logic [31:0] pv;

    reset = 1'b1;
    invalid_opcode = 1'b1; overflow = 1'b1; div_zero = 1'b1;
    pc_in = 32'hDEAD_BEEF; mem_data = 8'hA5;
    invalid_opcode_4 = 1'b0; overflow_4 = 1'b1; div_zero_4 = 1'b1;
    pc_in_4 = 32'h1234_5678; mem_data_4 = 8'h5A;

    // Reset with flags held high
    step(); step();
    chk("rst_code",    32'(exc_code),  32'd0);
    chk("rst_epc_we",  32'(epc_write), 32'd0);
    chk("rst_epc_val", epc_value,      32'd0);
    chk("rst_mem_rd",  32'(mem_read),  32'd0);
    chk("rst_pc_we",   32'(pc_write),  32'd0);
    chk("rst_pc_val",  pc_value,       32'd0);
    chk("rst_busy",    32'(exc_busy),  32'd0);
    chk("rst_busy4",   32'(exc_busy_4), 32'd0);
    invalid_opcode = 1'b0; overflow = 1'b0; div_zero = 1'b0;
    overflow_4 = 1'b0; div_zero_4 = 1'b0;
    reset = 1'b0;
    step();
    chk("post_rst_busy", 32'(exc_busy), 32'd0);

    // Overflow, latency 1: SAVE_EPC, READ_VEC, LOAD_PC, then IDLE
    overflow = 1'b1; pc_in = 32'h40; mem_data = 8'h80;
    step();
    overflow = 1'b0;
    pc_in = 32'h9999_0000;
    chk("ovf_code",    32'(exc_code),  32'd1);
    chk("ovf_epc_we",  32'(epc_write), 32'd1);
    chk("ovf_epc_val", epc_value,      32'h3C);
    chk("ovf_busy_s",  32'(exc_busy),  32'd1);
    chk("ovf_rd_s",    32'(mem_read),  32'd0);
    step();
    chk("ovf_rd",      32'(mem_read),  32'd1);
    chk("ovf_epc_off", 32'(epc_write), 32'd0);
    chk("ovf_code_rd", 32'(exc_code),  32'd1);
    step();
    chk("ovf_pc_we",   32'(pc_write),  32'd1);
    chk("ovf_pc_val",  pc_value,       32'h80);
    chk("ovf_rd_off",  32'(mem_read),  32'd0);
    chk("ovf_busy_l",  32'(exc_busy),  32'd1);
    step();
    chk("ovf_busy_end", 32'(exc_busy), 32'd0);
    chk("ovf_pc_off",   32'(pc_write), 32'd0);

    // Priority: opcode over div0
    invalid_opcode = 1'b1; div_zero = 1'b1; pc_in = 32'h100; mem_data = 8'h11;
    step();
    invalid_opcode = 1'b0; div_zero = 1'b0;
    chk("prio_code", 32'(exc_code), 32'd0);
    chk("prio_epc",  epc_value,     32'hFC);
    drain(nb, ne, np, pv);
    chk("prio_busy", 32'(nb), 32'd3);
    chk("prio_pcv",  pv,      32'h11);

    // div0 alone with pc_in=0 wraps EPC
    div_zero = 1'b1; pc_in = 32'h0; mem_data = 8'h22;
    step();
    div_zero = 1'b0;
    chk("div_code", 32'(exc_code), 32'd2);
    chk("div_epc",  epc_value,     32'hFFFF_FFFC);
    drain(nb, ne, np, pv);
    chk("div_epcw_n", 32'(ne), 32'd1);
    chk("div_pcw_n",  32'(np), 32'd1);
    chk("div_pcv",    pv,      32'h22);

    // div0 pulsed during READ_VEC is dropped
    overflow = 1'b1; pc_in = 32'h200; mem_data = 8'h33;
    step();
    overflow = 1'b0;
    step();
    chk("ign_rd", 32'(mem_read), 32'd1);
    div_zero = 1'b1;
    step();
    div_zero = 1'b0;
    chk("ign_pc_we", 32'(pc_write), 32'd1);
    chk("ign_code",  32'(exc_code), 32'd1);
    step();
    chk("ign_busy1", 32'(exc_busy), 32'd0);
    step();
    chk("ign_busy2", 32'(exc_busy), 32'd0);
    chk("ign_code2", 32'(exc_code), 32'd1);

    // Reset during READ_VEC
    div_zero = 1'b1; pc_in = 32'h300; mem_data = 8'h77;
    step();
    div_zero = 1'b0;
    step();
    chk("mid_rd", 32'(mem_read), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(exc_busy), 32'd0);
    chk("mid_rst_rd",   32'(mem_read), 32'd0);
    chk("mid_rst_code", 32'(exc_code), 32'd0);
    chk("mid_rst_epc",  epc_value,     32'd0);
    @(negedge clk);
    reset = 1'b0;
    npulse = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (pc_write || epc_write || exc_busy) npulse++;
    end
    chk("mid_rst_quiet", 32'(npulse), 32'd0);
    overflow = 1'b1; pc_in = 32'h44; mem_data = 8'h5A;
    step();
    overflow = 1'b0;
    chk("after_rst_code", 32'(exc_code), 32'd1);
    chk("after_rst_epc",  epc_value,     32'h40);
    drain(nb, ne, np, pv);
    chk("after_rst_busy", 32'(nb), 32'd3);
    chk("after_rst_pcw",  32'(np), 32'd1);
    chk("after_rst_pcv",  pv,      32'h5A);

    // Flag held through LOAD_PC restarts after a single IDLE cycle
    overflow = 1'b1; pc_in = 32'h10; mem_data = 8'h01;
    step(); step(); step();
    chk("b2b_load", 32'(pc_write), 32'd1);
    step();
    chk("b2b_gap",  32'(exc_busy), 32'd0);
    step();
    overflow = 1'b0;
    chk("b2b_restart", 32'(epc_write), 32'd1);
    drain(nb, ne, np, pv);
    chk("b2b_busy2", 32'(nb), 32'd3);

    // Latency 4, data valid only on the last read cycle
    invalid_opcode_4 = 1'b1; pc_in_4 = 32'h1000; mem_data_4 = 8'h13;
    step();
    invalid_opcode_4 = 1'b0;
    chk("l4_code", 32'(exc_code_4), 32'd0);
    chk("l4_epc",  epc_value_4,     32'hFFC);
    nb = 0; rd = 0; np = 0; pv = 32'hFFFF_FFFF;
    for (int i = 0; i < 32 && exc_busy_4; i++) begin
      nb++;
      if (mem_read_4) begin
        rd++;
        mem_data_4 = (rd == 4) ? 8'hFE : 8'h13;
      end else begin
        mem_data_4 = 8'h13;
      end
      if (pc_write_4) begin
        np++;
        pv = pc_value_4;
      end
      step();
    end
    chk("l4_timeout", 32'(exc_busy_4), 32'd0);
    chk("l4_busy",    32'(nb), 32'd6);
    chk("l4_reads",   32'(rd), 32'd4);
    chk("l4_pcw",     32'(np), 32'd1);
    chk("l4_pcv",     pv,      32'hFE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
